mac_operand_server: RTL and testbench

//   Operand store that answers mac_stop_mult read requests. It holds matrix A (MxK) and matrix B (KxN).
//   A host write port fills both matrices; the block then locks them and reports operands_ready.
//   It returns A/B elements one cycle after each matrix_a_re/matrix_b_re request and rejects illegal accesses.

---
 rtl/mac_operand_server_if.sv | 50 +++++
 rtl/mac_operand_server.sv | 174 +++++++++++++++++
 tb/tb_mac_operand_server.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_server_if.sv
// Host write port, operand read port and status of mac_operand_server.
// The host drives the master side. The operand server drives the slave side.
interface mac_operand_server_if #(
  parameter int M  = 4,
  parameter int K  = 4,
  parameter int N  = 4,
  parameter int DW = 32
);
  localparam int MAXD = (M > K) ? ((M > N) ? M : N) : ((K > N) ? K : N);
  localparam int AW   = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int MW   = (M > 1) ? $clog2(M) : 1;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int NW   = (N > 1) ? $clog2(N) : 1;

  logic          clear;
  logic          mac_done;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_row;
  logic [AW-1:0] wr_col;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          matrix_a_re;
  logic [MW-1:0] row_addr_a;
  logic [KW-1:0] col_addr_a;
  logic          matrix_b_re;
  logic [KW-1:0] row_addr_b;
  logic [NW-1:0] col_addr_b;
  logic [DW-1:0] data_in_a;
  logic [DW-1:0] data_in_b;
  logic          data_a_valid;
  logic          data_b_valid;
  logic          rd_err;
  logic          operands_ready;
  logic [1:0]    state;

  modport master (
    output clear, mac_done, wr_en, wr_sel, wr_row, wr_col, wr_data,
           matrix_a_re, row_addr_a, col_addr_a, matrix_b_re, row_addr_b, col_addr_b,
    input  wr_err, data_in_a, data_in_b, data_a_valid, data_b_valid, rd_err,
           operands_ready, state
  );

  modport slave (
    input  clear, mac_done, wr_en, wr_sel, wr_row, wr_col, wr_data,
           matrix_a_re, row_addr_a, col_addr_a, matrix_b_re, row_addr_b, col_addr_b,
    output wr_err, data_in_a, data_in_b, data_a_valid, data_b_valid, rd_err,
           operands_ready, state
  );
endinterface

// File: rtl/mac_operand_server.sv
// Operand store for the MAC. It holds A (MxK) and B (KxN), locks them once every element is written, and serves reads.
// Reads have a fixed latency of 1 cycle with no backpressure. Rejected writes and reads raise 1-cycle error pulses.
module mac_operand_server #(
  parameter int M                      = 4,
  parameter int K                      = 4,
  parameter int N                      = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
  input logic                 clk,
  input logic                 reset,
  mac_operand_server_if.slave bus
);
  localparam int DW  = DATA_WIDTH_INIT_MATRIX;
  localparam int NA  = M * K;
  localparam int NB  = K * N;
  localparam int IAW = (NA > 1) ? $clog2(NA) : 1;
  localparam int IBW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CAW = $clog2(NA + 1);
  localparam int CBW = $clog2(NB + 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_LOADING = 2'b01,
    ST_READY   = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  mem_a [NA];
  logic [DW-1:0]  mem_b [NB];
  logic [NA-1:0]  va_q, va_d;
  logic [NB-1:0]  vb_q, vb_d;
  logic [CAW-1:0] cnta_q, cnta_d;
  logic [CBW-1:0] cntb_q, cntb_d;
  logic           wr_acc, wr_in_rng, full;
  logic           wr_err_q, wr_err_d;
  logic [IAW-1:0] wr_idx_a, rd_idx_a;
  logic [IBW-1:0] wr_idx_b, rd_idx_b;
  logic           rd_ok, rd_a_rng, rd_b_rng;
  logic [DW-1:0]  data_a_q, data_a_d, data_b_q, data_b_d;
  logic           a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic           rd_err_q, rd_err_d;

  assign wr_idx_a  = IAW'(bus.wr_row) * IAW'(K) + IAW'(bus.wr_col);
  assign wr_idx_b  = IBW'(bus.wr_row) * IBW'(N) + IBW'(bus.wr_col);
  assign rd_idx_a  = IAW'(bus.row_addr_a) * IAW'(K) + IAW'(bus.col_addr_a);
  assign rd_idx_b  = IBW'(bus.row_addr_b) * IBW'(N) + IBW'(bus.col_addr_b);
  assign wr_in_rng = bus.wr_sel ? ((32'(bus.wr_row) < K) && (32'(bus.wr_col) < N))
                                : ((32'(bus.wr_row) < M) && (32'(bus.wr_col) < K));
  assign rd_a_rng  = (32'(bus.row_addr_a) < M) && (32'(bus.col_addr_a) < K);
  assign rd_b_rng  = (32'(bus.row_addr_b) < K) && (32'(bus.col_addr_b) < N);

  // clear outranks the write, so a write that coincides with clear is dropped silently.
  always_comb begin
    va_d     = va_q;
    vb_d     = vb_q;
    cnta_d   = cnta_q;
    cntb_d   = cntb_q;
    wr_acc   = 1'b0;
    wr_err_d = 1'b0;
    if (bus.clear) begin
      va_d   = '0;
      vb_d   = '0;
      cnta_d = '0;
      cntb_d = '0;
    end else if (bus.wr_en) begin
      if ((state_q != ST_READY) && wr_in_rng) begin
        wr_acc = 1'b1;
        if (!bus.wr_sel) begin
          if (!va_q[wr_idx_a]) cnta_d = cnta_q + CAW'(1);
          va_d[wr_idx_a] = 1'b1;
        end else begin
          if (!vb_q[wr_idx_b]) cntb_d = cntb_q + CBW'(1);
          vb_d[wr_idx_b] = 1'b1;
        end
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  assign full = (cnta_d == CAW'(NA)) && (cntb_d == CBW'(NB));

  always_ff @(posedge clk) begin
    if (wr_acc && !reset && !bus.wr_sel) mem_a[wr_idx_a] <= bus.wr_data;
    if (wr_acc && !reset &&  bus.wr_sel) mem_b[wr_idx_b] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // After an unlock the store stays in LOADING until a patch write lands, giving the host time to edit.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY:   if (wr_acc) state_d = full ? ST_READY : ST_LOADING;
        ST_LOADING: if (wr_acc && full) state_d = ST_READY;
        ST_READY:   if (bus.mac_done) state_d = ST_LOADING;
        default:    state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.operands_ready = (state_q == ST_READY);
    bus.state          = state_q;
  end

  // A read coinciding with mac_done is already outside the locked window.
  assign rd_ok = (state_q == ST_READY) && !bus.mac_done;

  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    a_vld_d  = 1'b0;
    b_vld_d  = 1'b0;
    rd_err_d = 1'b0;
    if (bus.matrix_a_re) begin
      if (rd_ok && rd_a_rng) begin
        data_a_d = mem_a[rd_idx_a];
        a_vld_d  = 1'b1;
      end else begin
        data_a_d = '0;
        rd_err_d = 1'b1;
      end
    end
    if (bus.matrix_b_re) begin
      if (rd_ok && rd_b_rng) begin
        data_b_d = mem_b[rd_idx_b];
        b_vld_d  = 1'b1;
      end else begin
        data_b_d = '0;
        rd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      va_q     <= '0;
      vb_q     <= '0;
      cnta_q   <= '0;
      cntb_q   <= '0;
      wr_err_q <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      va_q     <= va_d;
      vb_q     <= vb_d;
      cnta_q   <= cnta_d;
      cntb_q   <= cntb_d;
      wr_err_q <= wr_err_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign bus.wr_err       = wr_err_q;
  assign bus.data_in_a    = data_a_q;
  assign bus.data_in_b    = data_b_q;
  assign bus.data_a_valid = a_vld_q;
  assign bus.data_b_valid = b_vld_q;
  assign bus.rd_err       = rd_err_q;
endmodule

// File: tb/tb_mac_operand_server.sv
// Directed bench for mac_operand_server. Stimulus pushes expected responses; negedge monitors pop and compare.
module tb_mac_operand_server;
  logic clk;
  logic reset;

  mac_operand_server_if #(.M(4), .K(4), .N(4), .DW(32)) bus ();
  mac_operand_server_if #(.M(3), .K(2), .N(3), .DW(8))  bus_s ();

  mac_operand_server #(.M(4), .K(4), .N(4), .DATA_WIDTH_INIT_MATRIX(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  // At 4x4 every 2-bit index is legal, so index-range rejection is exercised on a 3x2x3 store.
  mac_operand_server #(.M(3), .K(2), .N(3), .DATA_WIDTH_INIT_MATRIX(8)) dut_small (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  int a_m [16] = '{6, 2, 5, 2, 6, 2, 6, 1, 2, 4, 5, 2, 7, 2, 5, 1};
  int b_m [16] = '{1, 1, 4, 4, 1, 7, 2, 1, 3, 2, 1, 1, 2, 1, 6, 6};

  logic [31:0] qa[$], qb[$], qe[$], qw[$], qw2[$];
  int n_vec  = 0;
  int n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] got);
    n_vec++;
    n_miss++;
    $display("FAIL %s: unexpected output, value %0d, none expected", nm, got);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clear = 1'b0; bus.mac_done = 1'b0; bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
    bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.matrix_a_re = 1'b0; bus.row_addr_a = '0; bus.col_addr_a = '0;
    bus.matrix_b_re = 1'b0; bus.row_addr_b = '0; bus.col_addr_b = '0;
  endtask

  task automatic idle_s();
    bus_s.clear = 1'b0; bus_s.mac_done = 1'b0; bus_s.wr_en = 1'b0; bus_s.wr_sel = 1'b0;
    bus_s.wr_row = '0; bus_s.wr_col = '0; bus_s.wr_data = '0;
    bus_s.matrix_a_re = 1'b0; bus_s.row_addr_a = '0; bus_s.col_addr_a = '0;
    bus_s.matrix_b_re = 1'b0; bus_s.row_addr_b = '0; bus_s.col_addr_b = '0;
  endtask

  task automatic drive_wr(input logic sel, input int r, input int c, input int d);
    bus.wr_en = 1'b1; bus.wr_sel = sel;
    bus.wr_row = 2'(r); bus.wr_col = 2'(c); bus.wr_data = 32'(d);
  endtask

  task automatic wr_elem(input int i);
    if (i < 16) drive_wr(1'b0, i / 4, i % 4, a_m[i]);
    else        drive_wr(1'b1, (i - 16) / 4, (i - 16) % 4, b_m[i - 16]);
  endtask

  task automatic rd_a(input int r, input int c);
    bus.matrix_a_re = 1'b1; bus.row_addr_a = 2'(r); bus.col_addr_a = 2'(c);
  endtask

  task automatic rd_b(input int r, input int c);
    bus.matrix_b_re = 1'b1; bus.row_addr_b = 2'(r); bus.col_addr_b = 2'(c);
  endtask

  task automatic fill_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      wr_elem(i);
      step();
      if (i == 0)  chk({tag, "_loading_after_first"}, 32'(bus.state), 1);
      if (i == 30) chk({tag, "_not_ready_after_31"}, 32'(bus.operands_ready), 0);
    end
    idle();
    chk({tag, "_ready_after_32"}, 32'(bus.operands_ready), 1);
    chk({tag, "_state_ready"}, 32'(bus.state), 2);
  endtask

  task automatic wr_small(input logic sel, input int r, input int c, input logic exp_err);
    bus_s.wr_en = 1'b1; bus_s.wr_sel = sel;
    bus_s.wr_row = 2'(r); bus_s.wr_col = 2'(c); bus_s.wr_data = 8'hA5;
    if (exp_err) qw2.push_back(32'd0);
    step();
    idle_s();
  endtask

  always @(negedge clk) begin
    if (bus.data_a_valid) begin
      if (qa.size() == 0) unexpected("rd_a", bus.data_in_a);
      else chk("rd_a_data", bus.data_in_a, qa.pop_front());
    end
    if (bus.data_b_valid) begin
      if (qb.size() == 0) unexpected("rd_b", bus.data_in_b);
      else chk("rd_b_data", bus.data_in_b, qb.pop_front());
    end
    if (bus.rd_err) begin
      if (qe.size() == 0) unexpected("rd_err", 32'(bus.rd_err));
      else begin
        chk("rd_err_data_a", bus.data_in_a, qe.pop_front());
        chk("rd_err_valid_a", 32'(bus.data_a_valid), 0);
      end
    end
    if (bus.wr_err) begin
      if (qw.size() == 0) unexpected("wr_err", 32'(bus.wr_err));
      else chk("wr_err_state", 32'(bus.state), qw.pop_front());
    end
    if (bus_s.wr_err) begin
      if (qw2.size() == 0) unexpected("small_wr_err", 32'(bus_s.wr_err));
      else chk("small_wr_err_state", 32'(bus_s.state), qw2.pop_front());
    end
  end

  initial begin
    idle();
    idle_s();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_ready", 32'(bus.operands_ready), 0);
    chk("rst_data_a", bus.data_in_a, 0);
    chk("rst_data_b", bus.data_in_b, 0);
    chk("rst_valids", {30'd0, bus.data_a_valid, bus.data_b_valid}, 0);
    chk("rst_errs", {30'd0, bus.wr_err, bus.rd_err}, 0);

    // Out-of-range writes: A row 3 (M=3), A col 2 (K=2), B row 2 (K=2), B col 3 (N=3).
    wr_small(1'b0, 3, 0, 1'b1);
    wr_small(1'b0, 0, 2, 1'b1);
    wr_small(1'b1, 2, 0, 1'b1);
    wr_small(1'b1, 0, 3, 1'b1);
    chk("small_still_empty", 32'(bus_s.state), 0);
    wr_small(1'b0, 2, 1, 1'b0);
    chk("small_loading", 32'(bus_s.state), 1);

    fill_all("fill");

    rd_a(3, 0); rd_b(1, 1);
    qa.push_back(32'd7); qb.push_back(32'd7);
    step();
    idle();

    for (int c = 0; c < 4; c++) begin
      rd_a(0, c);
      qa.push_back(32'(a_m[c]));
      step();
    end
    idle();

    drive_wr(1'b0, 1, 1, 99);
    qw.push_back(32'd2);
    step();
    idle();
    chk("ready_after_rejected_wr", 32'(bus.operands_ready), 1);

    bus.mac_done = 1'b1;
    rd_a(0, 0);
    qe.push_back(32'd0);
    step();
    idle();
    chk("unlock_loading", 32'(bus.state), 1);
    rd_a(2, 1);
    qe.push_back(32'd0);
    step();
    idle();

    drive_wr(1'b0, 0, 0, 9);
    step();
    idle();
    chk("patch_ready", 32'(bus.state), 2);
    rd_a(0, 0); rd_b(3, 3);
    qa.push_back(32'd9); qb.push_back(32'd6);
    step();
    rd_a(1, 1); bus.matrix_b_re = 1'b0;
    qa.push_back(32'd2);
    step();
    idle();

    bus.clear = 1'b1;
    step();
    idle();
    chk("clear_empty", 32'(bus.state), 0);
    for (int i = 0; i < 10; i++) begin wr_elem(i); step(); end
    wr_elem(10);
    bus.clear = 1'b1;
    step();
    idle();
    chk("clear_mid_load_empty", 32'(bus.state), 0);
    fill_all("after_clear");
    rd_a(0, 0);
    qa.push_back(32'd6);
    step();
    idle();

    bus.clear = 1'b1;
    step();
    idle();
    for (int i = 0; i < 10; i++) begin wr_elem(i); step(); end
    wr_elem(10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    chk("reset_mid_load_state", 32'(bus.state), 0);
    chk("reset_mid_load_data_a", bus.data_in_a, 0);
    chk("reset_mid_load_ready", 32'(bus.operands_ready), 0);
    chk("reset_mid_load_flags",
        {28'd0, bus.data_a_valid, bus.data_b_valid, bus.wr_err, bus.rd_err}, 0);
    fill_all("after_reset");
    rd_b(1, 1);
    qb.push_back(32'd7);
    step();
    idle();

    step();
    step();
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    chk("rd_err_drained", 32'(qe.size()), 0);
    chk("wr_err_drained", 32'(qw.size()), 0);
    chk("small_wr_err_drained", 32'(qw2.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
